// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues to a 1-cycle synchronous IMEM and
// presents {instr, pc, valid} to decode, with a hold register and a deferred redirect across stalls.
module fetch_unit #(
  parameter int          PC_W     = 27,
  parameter int          IMEM_AW  = 25,
  parameter logic [26:0] RESET_PC = 27'h0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               n_stall,
  input  logic [PC_W-1:0]    npc,
  input  logic               npc_enn,
  input  logic               flush,
  output logic               imem_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        if_instr,
  output logic [PC_W-1:0]    if_pc,
  output logic               if_valid
);

  logic [PC_W-1:0] pc_f;
  logic [PC_W-1:0] req_pc;
  logic            req_valid;
  logic            hold_valid;
  logic [31:0]     hold_instr;
  logic            redir_pend;
  logic [PC_W-1:0] redir_pc;

  logic [PC_W-1:0] t_raw;
  logic [PC_W-1:0] t;

  // A live redirect beats a deferred one, which beats sequential fetch.
  always_comb begin
    t_raw = pc_f;
    if (npc_enn)         t_raw = npc;
    else if (redir_pend) t_raw = redir_pc;
    t = {t_raw[PC_W-1:2], 2'b00};
  end

  assign imem_en   = n_stall & ~rst;
  assign imem_addr = t[PC_W-1:2];

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_f       <= PC_W'(RESET_PC);
      req_pc     <= '0;
      req_valid  <= 1'b0;
      hold_valid <= 1'b0;
      hold_instr <= '0;
      redir_pend <= 1'b0;
      redir_pc   <= '0;
    end else if (n_stall) begin
      req_pc     <= t;
      req_valid  <= 1'b1;
      pc_f       <= t + PC_W'(4);
      hold_valid <= 1'b0;
      redir_pend <= 1'b0;
    end else begin
      // The first stalled edge still sees the live read data; capture it once.
      if (!hold_valid) begin
        hold_instr <= imem_rdata;
        hold_valid <= 1'b1;
      end
      if (npc_enn) begin
        redir_pend <= 1'b1;
        redir_pc   <= npc;
      end
    end
  end

  assign if_instr = !req_valid ? 32'h0 : (hold_valid ? hold_instr : imem_rdata);
  assign if_pc    = req_pc;
  assign if_valid = req_valid & ~flush & ~redir_pend;

endmodule
